// File: rtl/simon_playback_sequencer_if.sv
// Signal bundle between the Simon playback sequencer and the game FSM, sequence RAM and LED/tone drivers.
// The sequencer uses the slave modport; the surrounding system drives through the master modport.
interface simon_playback_sequencer_if #(
    parameter int MAX_LEN = 32,
    parameter int TPM_W   = 16
);
    localparam int AW = $clog2(MAX_LEN);

    logic [TPM_W-1:0] ticks_per_milli;
    logic             start;
    logic             abort;
    logic [AW:0]      seq_len;
    logic [AW-1:0]    rd_addr;
    logic [1:0]       rd_data;
    logic [3:0]       led;
    logic             tone_en;
    logic [1:0]       tone_idx;
    logic             busy;
    logic             done;

    modport master (
        output ticks_per_milli, start, abort, seq_len, rd_data,
        input  rd_addr, led, tone_en, tone_idx, busy, done
    );

    modport slave (
        input  ticks_per_milli, start, abort, seq_len, rd_data,
        output rd_addr, led, tone_en, tone_idx, busy, done
    );
endinterface

// File: rtl/simon_playback_sequencer.sv
// Plays the stored Simon colour sequence: for each RAM entry, LED + tone for ON_MS ms,
// then a dark silent gap of GAP_MS ms. All outputs are registered.
module simon_playback_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int ON_MS   = 300,
    parameter int GAP_MS  = 100,
    parameter int TPM_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    simon_playback_sequencer_if.slave    bus
);
    localparam int AW     = $clog2(MAX_LEN);
    localparam int MS_MAX = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
    localparam int MS_W   = $clog2(MS_MAX) + 1;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_ON, S_GAP, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    idx_reg, idx_next;
    logic [AW:0]      len_reg, len_next;
    logic [AW-1:0]    rd_addr_reg, rd_addr_next;
    logic [3:0]       led_reg, led_next;
    logic             tone_en_reg, tone_en_next;
    logic [1:0]       tone_idx_reg, tone_idx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [TPM_W-1:0] tick_reg, tick_next;
    logic [MS_W-1:0]  ms_reg, ms_next;

    logic [TPM_W-1:0] tpm_lim;
    logic [MS_W-1:0]  ms_limit;
    logic [AW:0]      len_in;
    logic [3:0]       led_dec;
    logic             ms_tick;
    logic             phase_end;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_led
            assign led_dec[gi] = (bus.rd_data == 2'(gi));
        end
    endgenerate

    // A ticks_per_milli of 0 behaves as 1; >= compare lets a shrunken limit wrap at once.
    assign tpm_lim   = (bus.ticks_per_milli == '0) ? TPM_W'(1) : bus.ticks_per_milli;
    assign ms_tick   = (tick_reg >= tpm_lim - 1'b1);
    assign ms_limit  = (state_reg == S_ON) ? MS_W'(ON_MS) : MS_W'(GAP_MS);
    assign phase_end = ms_tick && (ms_reg == ms_limit - 1'b1);
    assign len_in    = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        len_next      = len_reg;
        rd_addr_next  = rd_addr_reg;
        led_next      = led_reg;
        tone_en_next  = tone_en_reg;
        tone_idx_next = tone_idx_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        tick_next     = '0;
        ms_next       = '0;

        // Timers run only inside a phase and restart whenever a phase is entered.
        if ((state_reg == S_ON || state_reg == S_GAP) && !phase_end) begin
            if (ms_tick) begin
                ms_next = ms_reg + 1'b1;
            end else begin
                tick_next = tick_reg + 1'b1;
                ms_next   = ms_reg;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.seq_len != '0) begin
                        state_next   = S_FETCH;
                        len_next     = len_in;
                        idx_next     = '0;
                        rd_addr_next = '0;
                        busy_next    = 1'b1;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_FETCH: state_next = S_LATCH;
            S_LATCH: begin
                state_next    = S_ON;
                led_next      = led_dec;
                tone_en_next  = 1'b1;
                tone_idx_next = bus.rd_data;
            end
            S_ON: begin
                if (phase_end) begin
                    state_next   = S_GAP;
                    led_next     = '0;
                    tone_en_next = 1'b0;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    if ({1'b0, idx_reg} == len_reg - 1'b1) begin
                        state_next = S_DONE;
                    end else begin
                        state_next   = S_FETCH;
                        idx_next     = idx_reg + 1'b1;
                        rd_addr_next = idx_reg + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                done_next  = 1'b1;
                busy_next  = 1'b0;
            end
            default: state_next = S_IDLE;
        endcase

        // Abort freezes address/index/tone select and only darkens and idles the block.
        if (bus.abort && state_reg != S_IDLE) begin
            state_next    = S_IDLE;
            idx_next      = idx_reg;
            len_next      = len_reg;
            rd_addr_next  = rd_addr_reg;
            tone_idx_next = tone_idx_reg;
            led_next      = '0;
            tone_en_next  = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b0;
            tick_next     = '0;
            ms_next       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            len_reg      <= '0;
            rd_addr_reg  <= '0;
            led_reg      <= '0;
            tone_en_reg  <= 1'b0;
            tone_idx_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            tick_reg     <= '0;
            ms_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            len_reg      <= len_next;
            rd_addr_reg  <= rd_addr_next;
            led_reg      <= led_next;
            tone_en_reg  <= tone_en_next;
            tone_idx_reg <= tone_idx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            tick_reg     <= tick_next;
            ms_reg       <= ms_next;
        end
    end

    assign bus.rd_addr  = rd_addr_reg;
    assign bus.led      = led_reg;
    assign bus.tone_en  = tone_en_reg;
    assign bus.tone_idx = tone_idx_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Scoreboard bench: each play schedules its expected output-change events; a negedge monitor
// pops and compares one event every time the DUT's observable outputs change.
module tb_simon_playback_sequencer;
    localparam int MAX_LEN = 32;
    localparam int ON_MS   = 3;
    localparam int GAP_MS  = 2;
    localparam int TPM_W   = 16;
    localparam int AW      = 5;

    typedef struct packed {
        logic [AW-1:0] rd_addr;
        logic [3:0]    led;
        logic          tone_en;
        logic [1:0]    tone_idx;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct packed {
        int   t;
        obs_t v;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    ev_t        sb[$];
    obs_t       mdl      = '0;
    obs_t       mon_prev = '0;
    bit         mon_en   = 1'b0;
    int         cut      = 1 << 30;
    logic [1:0] ram [MAX_LEN];

    simon_playback_sequencer_if #(.MAX_LEN(MAX_LEN), .TPM_W(TPM_W)) bus ();

    simon_playback_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_MS(ON_MS), .GAP_MS(GAP_MS), .TPM_W(TPM_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

    function automatic obs_t sample();
        obs_t s;
        s.rd_addr  = bus.rd_addr;
        s.led      = bus.led;
        s.tone_en  = bus.tone_en;
        s.tone_idx = bus.tone_idx;
        s.busy     = bus.busy;
        s.done     = bus.done;
        return s;
    endfunction

    function automatic void push_ev(int t, obs_t v);
        if (t > cut || v == mdl) return;
        sb.push_back('{t: t, v: v});
        mdl = v;
    endfunction

    // Reference timeline: start sampled at edge e; outputs seen from cycle e onwards.
    function automatic void build_plan(int e, int n_raw, int tpm);
        int   n   = (n_raw > MAX_LEN) ? MAX_LEN : n_raw;
        int   lim = (tpm == 0) ? 1 : tpm;
        int   p   = 2 + (ON_MS + GAP_MS) * lim;
        int   base;
        obs_t v   = mdl;
        if (n == 0) begin
            v.done = 1'b1; push_ev(e + 1, v);
            v.done = 1'b0; push_ev(e + 2, v);
            return;
        end
        v.busy = 1'b1; v.rd_addr = '0; push_ev(e, v);
        for (int s = 0; s < n; s++) begin
            base = e + s * p;
            if (s > 0) begin v.rd_addr = AW'(s); push_ev(base, v); end
            v.led = 4'b0001 << ram[s]; v.tone_en = 1'b1; v.tone_idx = ram[s];
            push_ev(base + 2, v);
            v.led = '0; v.tone_en = 1'b0;
            push_ev(base + 2 + ON_MS * lim, v);
        end
        v.busy = 1'b0; v.done = 1'b1; push_ev(e + n * p + 1, v);
        v.done = 1'b0; push_ev(e + n * p + 2, v);
    endfunction

    always @(negedge clk) begin : monitor
        obs_t cur;
        ev_t  ex;
        if (mon_en) begin
            cur = sample();
            if (cur !== mon_prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cycle=%0d got=%h required=no change", cyc, cur);
                end else begin
                    ex = sb.pop_front();
                    if (ex.t != cyc || ex.v !== cur) begin
                        errors++;
                        $display("FAIL output_event got cycle=%0d vec=%h required cycle=%0d vec=%h",
                                 cyc, cur, ex.t, ex.v);
                    end else begin
                        $display("event cycle=%0d addr=%0d led=%b tone=%b/%0d busy=%b done=%b",
                                 cyc, cur.rd_addr, cur.led, cur.tone_en, cur.tone_idx, cur.busy, cur.done);
                    end
                end
                mon_prev = cur;
            end
        end
    end

    task automatic run_play(input int n_raw, input int tpm, input int abort_off,
                            input int rst_off, input bit noise);
        int   e, k_ab, k_rs, n, lim, p, last;
        obs_t v;
        @(negedge clk);
        bus.ticks_per_milli = TPM_W'(tpm);
        bus.seq_len         = 6'(n_raw);
        bus.start           = 1'b1;
        e    = cyc + 1;
        k_ab = (abort_off >= 0) ? e + abort_off : -1;
        k_rs = (rst_off >= 0) ? e + rst_off : -1;
        cut  = (k_ab >= 0) ? k_ab : ((k_rs >= 0) ? k_rs : (1 << 30));
        build_plan(e, n_raw, tpm);
        cut  = 1 << 30;
        if (k_ab >= 0) begin
            v = mdl; v.led = '0; v.tone_en = 1'b0; v.busy = 1'b0; v.done = 1'b0;
            push_ev(k_ab + 1, v);
        end
        if (k_rs >= 0) push_ev(k_rs + 1, '0);
        n    = (n_raw > MAX_LEN) ? MAX_LEN : n_raw;
        lim  = (tpm == 0) ? 1 : tpm;
        p    = 2 + (ON_MS + GAP_MS) * lim;
        last = e + n * p + 10;
        while ((sb.size() != 0 || cyc < e + 3) && cyc < last) begin
            @(negedge clk);
            bus.start = noise && (cyc >= e) && (cyc <= e + n * p - 2) && ($urandom_range(0, 7) == 0);
            if (noise && $urandom_range(0, 3) == 0) bus.seq_len = 6'($urandom);
            bus.abort = (cyc == k_ab);
            if (cyc == k_rs) begin
                #1 rst_n = 1'b0;
                #1;
                checks++;
                if (sample() !== '0) begin
                    errors++;
                    $display("FAIL async_reset got=%h required=%h", sample(), obs_t'('0));
                end
            end else if (!rst_n) begin
                #1 rst_n = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0 next_cycle=%0d", sb.size(), sb[0].t);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_ram();
        for (int i = 0; i < MAX_LEN; i++) ram[i] = 2'($urandom);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.seq_len = '0;
        bus.ticks_per_milli = TPM_W'(2);
        fill_ram();
        repeat (3) @(negedge clk);
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h required=%h", sample(), obs_t'('0));
        end
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
        run_play(3, 2, -1, -1, 1'b0);
        run_play(0, 2, -1, -1, 1'b0);
        run_play(3, 2, 15, -1, 1'b0);
        run_play(3, 2, -1, -1, 1'b0);
        run_play(3, 2, -1, 4, 1'b0);
        run_play(3, 2, -1, -1, 1'b0);
        run_play(3, 2, -1, -1, 1'b1);

        fill_ram();
        run_play(2, 0, -1, -1, 1'b0);
        run_play(2, 1, -1, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_ram();
            run_play($urandom_range(1, 5), $urandom_range(0, 3), -1, -1, 1'($urandom_range(0, 1)));
        end

        fill_ram();
        run_play($urandom_range(33, 63), 1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
